seq_capture_buf: RTL and testbench

Capture buffer that sits directly downstream of the 16-bit Fibonacci sequence generator. On a start pulse it records a burst of DEPTH consecutive samples of the generator output into an internal register-file memory and flags the first 16-bit arithmetic wrap (a sample smaller than its predecessor). It then drains the burst through a valid/ready read port, which gives the memory test path a bounded, inspectable snapshot of the sequence.

---
 rtl/seq_capture_buf.sv | 110 +++++++++++
 tb/tb_seq_capture_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_capture_buf.sv
// Captures a burst of DEPTH consecutive generator samples, flags the first unsigned wrap,
// then drains the burst in order through a valid/ready read port.
module seq_capture_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_index,
    output logic              busy,
    output logic              full,
    output logic              wrap_seen,
    output logic [ADDR_W-1:0] wrap_index
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_next;

    assign rd_next = rd_index + ADDR_W'(1);

    // Sample storage has no reset; only CAPTURE writes it, so a drain never sees din.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            mem[wr_ptr] <= din;
        end
    end

    // Control FSM with every visible output registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            prev       <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_index   <= '0;
            busy       <= 1'b0;
            full       <= 1'b0;
            wrap_seen  <= 1'b0;
            wrap_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CAPTURE;
                        busy       <= 1'b1;
                        wr_ptr     <= '0;
                        wrap_seen  <= 1'b0;
                        wrap_index <= '0;
                    end
                end

                CAPTURE: begin
                    prev   <= din;
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    // The first slot has no predecessor, and only the first wrap is kept.
                    if ((wr_ptr != '0) && !wrap_seen && (din < prev)) begin
                        wrap_seen  <= 1'b1;
                        wrap_index <= wr_ptr;
                    end
                    if (wr_ptr == LAST) begin
                        state    <= DRAIN;
                        wr_ptr   <= '0;
                        full     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_index <= '0;
                        rd_data  <= mem[0];
                    end
                end

                DRAIN: begin
                    if (rd_valid && rd_ready) begin
                        if (rd_index == LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rd_valid <= 1'b0;
                            full     <= 1'b0;
                        end else begin
                            rd_index <= rd_next;
                            rd_data  <= mem[rd_next];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_capture_buf.sv
// Directed bench for seq_capture_buf: reset, monotone and wrapping bursts,
// backpressure, ignored start pulses and back-to-back bursts.
module tb_seq_capture_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = 16'h0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  rd_index;
    logic        busy;
    logic        full;
    logic        wrap_seen;
    logic [3:0]  wrap_index;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] stim [16];

    seq_capture_buf #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index), .busy(busy),
        .full(full), .wrap_seen(wrap_seen), .wrap_index(wrap_index)
    );

    always #5 clk = ~clk;

    // Start edge, then stim[0..15] on the following 16 edges; returns at the first DRAIN negedge.
    task automatic capture_burst(input int pulse_at);
        @(negedge clk);
        start = 1'b1;
        din   = 16'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            din   = stim[i];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, busy, full, wrap_seen, rd_index, rd_data, wrap_index} !== 28'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_init: got %h expected 0",
                     {rd_valid, busy, full, wrap_seen, rd_index, rd_data, wrap_index});
        end
        rst = 1'b1;
        for (int i = 0; i < 16; i++) stim[i] = 16'h0100 + 16'(i);
        capture_burst(-1);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        n_cmp++;
        if ({rd_valid, full, busy, rd_index, rd_data} !== {3'b111, 4'd1, 16'h0101}) begin
            n_bad++;
            $display("[TB] FAIL reset_predrain: got %h expected %h",
                     {rd_valid, full, busy, rd_index, rd_data}, {3'b111, 4'd1, 16'h0101});
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({rd_valid, busy, full, wrap_seen, rd_index, rd_data, wrap_index} !== 28'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_async: got %h expected 0",
                     {rd_valid, busy, full, wrap_seen, rd_index, rd_data, wrap_index});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rd_valid, busy, full, rd_index, rd_data} !== 23'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_hold: got %h expected 0", {rd_valid, busy, full, rd_index, rd_data});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rd_valid, busy, full} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL reset_release: got %b expected 000", {rd_valid, busy, full});
        end
    endtask

    task automatic test_monotone;
        stim = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987};
        capture_burst(-1);
        n_cmp++;
        if ({rd_valid, full, busy} !== 3'b111) begin
            n_bad++;
            $display("[TB] FAIL mono_enter: got %b expected 111", {rd_valid, full, busy});
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({full, rd_index, rd_data} !== {1'b1, 4'(i), stim[i]}) begin
                n_bad++;
                $display("[TB] FAIL mono_entry%0d: got full=%b idx=%0d data=%0d expected 1/%0d/%0d",
                         i, full, rd_index, rd_data, i, stim[i]);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        n_cmp++;
        if ({rd_valid, full, busy, wrap_seen, rd_data} !== {4'b0000, 16'd987}) begin
            n_bad++;
            $display("[TB] FAIL mono_done: got v=%b f=%b b=%b w=%b data=%0d expected 0/0/0/0/987",
                     rd_valid, full, busy, wrap_seen, rd_data);
        end
    endtask

    task automatic test_wrap;
        stim = '{16'd233, 16'd377, 16'd610, 16'd987, 16'd1597, 16'd2584, 16'd4181, 16'd6765,
                 16'd10946, 16'd17711, 16'd28657, 16'd46368, 16'd9489, 16'd55857, 16'd65346, 16'd55667};
        capture_burst(-1);
        n_cmp++;
        if ({wrap_seen, wrap_index} !== {1'b1, 4'd12}) begin
            n_bad++;
            $display("[TB] FAIL wrap_flag: got seen=%b idx=%0d expected 1/12", wrap_seen, wrap_index);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({rd_index, rd_data} !== {4'(i), stim[i]}) begin
                n_bad++;
                $display("[TB] FAIL wrap_entry%0d: got idx=%0d data=%0d expected %0d/%0d",
                         i, rd_index, rd_data, i, stim[i]);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, wrap_seen, wrap_index} !== {1'b0, 1'b1, 4'd12}) begin
            n_bad++;
            $display("[TB] FAIL wrap_idle_hold: got busy=%b seen=%b idx=%0d expected 0/1/12",
                     busy, wrap_seen, wrap_index);
        end
    endtask

    task automatic test_backpressure;
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < 16; i++) stim[i] = 16'h2000 + 16'(i * 16'h0111);
        capture_burst(-1);
        while (idx < 16 && cyc < 100) begin
            n_cmp++;
            if ({rd_valid, rd_index, rd_data} !== {1'b1, 4'(idx), stim[idx]}) begin
                n_bad++;
                $display("[TB] FAIL bp_cycle%0d: got v=%b idx=%0d data=%h expected 1/%0d/%h",
                         cyc, rd_valid, rd_index, rd_data, idx, stim[idx]);
            end
            rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            @(negedge clk);
            if (rd_ready) idx++;
            cyc++;
        end
        rd_ready = 1'b0;
        n_cmp++;
        if ({idx == 16, rd_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL bp_done: got delivered=%0d v=%b busy=%b expected 16/0/0", idx, rd_valid, busy);
        end
    endtask

    task automatic test_start_ignored;
        for (int i = 0; i < 16; i++) stim[i] = 16'(i);
        capture_burst(5);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            start = (i == 3);
            n_cmp++;
            if ({busy, rd_index, rd_data} !== {1'b1, 4'(i), 16'(i)}) begin
                n_bad++;
                $display("[TB] FAIL ign_entry%0d: got busy=%b idx=%0d data=%0d expected 1/%0d/%0d",
                         i, busy, rd_index, rd_data, i, i);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        n_cmp++;
        if ({busy, wrap_seen} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL ign_done: got busy=%b seen=%b expected 0/0", busy, wrap_seen);
        end
    endtask

    task automatic test_back_to_back;
        stim[0] = 16'hFFFF;
        for (int i = 1; i < 16; i++) stim[i] = 16'(i - 1);
        capture_burst(-1);
        n_cmp++;
        if ({wrap_seen, wrap_index} !== {1'b1, 4'd1}) begin
            n_bad++;
            $display("[TB] FAIL b2b_wrap: got seen=%b idx=%0d expected 1/1", wrap_seen, wrap_index);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            start = (i == 15);
            n_cmp++;
            if ({rd_index, rd_data} !== {4'(i), stim[i]}) begin
                n_bad++;
                $display("[TB] FAIL b2b_entry%0d: got idx=%0d data=%h expected %0d/%h",
                         i, rd_index, rd_data, i, stim[i]);
            end
            @(negedge clk);
        end
        start = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, rd_valid} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL b2b_final_start: got busy=%b v=%b expected 0/0", busy, rd_valid);
        end
        for (int i = 0; i < 16; i++) stim[i] = 16'h0040 + 16'(i);
        capture_burst(-1);
        n_cmp++;
        if ({busy, full, wrap_seen, wrap_index, rd_data} !== {3'b110, 4'd0, 16'h0040}) begin
            n_bad++;
            $display("[TB] FAIL b2b_restart: got busy=%b full=%b seen=%b idx=%0d data=%h expected 1/1/0/0/0040",
                     busy, full, wrap_seen, wrap_index, rd_data);
        end
        rd_ready = 1'b1;
        repeat (16) @(negedge clk);
        rd_ready = 1'b0;
        n_cmp++;
        if ({busy, rd_data} !== {1'b0, 16'h004F}) begin
            n_bad++;
            $display("[TB] FAIL b2b_restart_done: got busy=%b data=%h expected 0/004F", busy, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_monotone();
        test_wrap();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
